// File: rtl/trace_sequencer_if.sv
// Table ROM bus for the trace sequencer.
// The ROM returns the word for tbl_addr one cycle after the address is presented.
interface trace_sequencer_if #(
  parameter int NUM_TRACES = 5,
  parameter int CELLS      = 16,
  parameter int ORDER_W    = 64
);
  localparam int AW = (NUM_TRACES > 1) ? $clog2(NUM_TRACES) : 1;
  localparam int TW = 8 + 9 + 6 + ORDER_W + CELLS;

  logic [AW-1:0] tbl_addr;
  logic [TW-1:0] tbl_data;

  modport master (output tbl_addr, input tbl_data);
  modport slave  (input tbl_addr, output tbl_data);
endinterface

// File: rtl/trace_sequencer.sv
// Tutorial spell-trace sequencer: fetches preset traces from a table ROM and advances when the player covers them.
// Optional feature: define TRACE_TIMEOUT_EN to build the per-trace timeout counter (TIMEOUT_CYC).
module trace_sequencer #(
  parameter int NUM_TRACES  = 5,
  parameter int CELLS       = 16,
  parameter int ORDER_W     = 64,
  parameter int MATCH_EXACT = 0,
`ifdef TRACE_TIMEOUT_EN
  parameter int TIMEOUT_CYC = 2**24,
`endif
  localparam int AW = (NUM_TRACES > 1) ? $clog2(NUM_TRACES) : 1,
  localparam int CW = $clog2(NUM_TRACES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               learn_mode,
  input  logic               trace_screen_on,
  input  logic               restart,
  input  logic [CELLS-1:0]   p1_traced,
  trace_sequencer_if.master  rom,
  output logic [CELLS-1:0]   trace_to_display,
  output logic [ORDER_W-1:0] trace_order,
  output logic [5:0]         trace_boxes,
  output logic [7:0]         initial_row,
  output logic [8:0]         initial_col,
  output logic [CW-1:0]      trace_count,
  output logic               end_game_early,
  output logic               trace_timeout
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_TRACES - 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(NUM_TRACES);
  localparam int ORD_LO = CELLS;
  localparam int BOX_LO = ORD_LO + ORDER_W;
  localparam int COL_LO = BOX_LO + 6;
  localparam int ROW_LO = COL_LO + 9;

  typedef enum logic [2:0] {FETCH, LOAD, WAIT_CLR, SHOW, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_d;
  logic          done_d;
  logic          load_en;
  logic          enable;
  logic          match;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == MAX_CNT) ? c : c + CW'(1);
  endfunction

  assign enable   = learn_mode & trace_screen_on;
  assign match    = (MATCH_EXACT != 0) ? (p1_traced == trace_to_display)
                                       : ((p1_traced & trace_to_display) == trace_to_display);
  assign rom.tbl_addr = idx_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = trace_count;
    done_d  = end_game_early;
    load_en = 1'b0;
    if (restart) begin
      state_d = FETCH;
      idx_d   = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        FETCH:    state_d = LOAD;
        LOAD: begin
          load_en = 1'b1;
          state_d = (idx_q == '0) ? SHOW : WAIT_CLR;
        end
        // A stroke still on the grid must lift before the next trace can be judged.
        WAIT_CLR: if (p1_traced == '0) state_d = SHOW;
        SHOW: begin
          if (enable && match) begin
            cnt_d = sat_inc(trace_count);
            if (idx_q == LAST_IDX) begin
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              idx_d   = idx_q + AW'(1);
              state_d = FETCH;
            end
          end
        end
        DONE:     state_d = DONE;
        default:  state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= FETCH;
      idx_q          <= '0;
      trace_count    <= '0;
      end_game_early <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      trace_count    <= cnt_d;
      end_game_early <= done_d;
    end
  end

  // ROM word is captured only in LOAD; restart in LOAD suppresses the capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trace_to_display <= '0;
      trace_order      <= '0;
      trace_boxes      <= '0;
      initial_row      <= '0;
      initial_col      <= '0;
    end else if (load_en) begin
      trace_to_display <= rom.tbl_data[CELLS-1:0];
      trace_order      <= rom.tbl_data[ORD_LO +: ORDER_W];
      trace_boxes      <= rom.tbl_data[BOX_LO +: 6];
      initial_col      <= rom.tbl_data[COL_LO +: 9];
      initial_row      <= rom.tbl_data[ROW_LO +: 8];
    end
  end

`ifdef TRACE_TIMEOUT_EN
  localparam int TOW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TOW-1:0] to_cnt_q;

  // Counter is held at zero outside SHOW, so entering SHOW always starts a fresh window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q      <= '0;
      trace_timeout <= 1'b0;
    end else begin
      trace_timeout <= 1'b0;
      if (restart || state_q != SHOW) begin
        to_cnt_q <= '0;
      end else if (enable && !match) begin
        if (to_cnt_q == TOW'(TIMEOUT_CYC - 1)) begin
          to_cnt_q      <= '0;
          trace_timeout <= 1'b1;
        end else begin
          to_cnt_q <= to_cnt_q + TOW'(1);
        end
      end
    end
  end
`else
  assign trace_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_trace_sequencer.sv
// Self-checking bench for trace_sequencer: table-driven match vectors, scoreboard of expected counts,
// and hand-written sequences for reload, WAIT_CLR, DONE, restart, mid-load reset and timeout.
module tb_trace_sequencer;
  localparam int N       = 5;
  localparam int CELLS   = 16;
  localparam int ORDER_W = 64;
  localparam int CW      = 3;
  localparam int TW      = 8 + 9 + 6 + ORDER_W + CELLS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic learn_mode = 1'b0;
  logic trace_screen_on = 1'b0;
  logic restart = 1'b0;
  logic [CELLS-1:0]   p1_traced = '0;
  logic [CELLS-1:0]   trace_to_display;
  logic [ORDER_W-1:0] trace_order;
  logic [5:0]         trace_boxes;
  logic [7:0]         initial_row;
  logic [8:0]         initial_col;
  logic [CW-1:0]      trace_count;
  logic               end_game_early;
  logic               trace_timeout;

  trace_sequencer_if #(.NUM_TRACES(N), .CELLS(CELLS), .ORDER_W(ORDER_W)) rom_bus ();

  trace_sequencer #(
    .NUM_TRACES(N), .CELLS(CELLS), .ORDER_W(ORDER_W), .MATCH_EXACT(0)
`ifdef TRACE_TIMEOUT_EN
    , .TIMEOUT_CYC(8)
`endif
  ) dut (
    .clk(clk), .reset(reset), .learn_mode(learn_mode), .trace_screen_on(trace_screen_on),
    .restart(restart), .p1_traced(p1_traced), .rom(rom_bus.master),
    .trace_to_display(trace_to_display), .trace_order(trace_order), .trace_boxes(trace_boxes),
    .initial_row(initial_row), .initial_col(initial_col), .trace_count(trace_count),
    .end_game_early(end_game_early), .trace_timeout(trace_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input int i);
    case (i)
      0: return 16'h0660;
      1: return 16'h00F0;
      2: return 16'h8001;
      3: return 16'h3C3C;
      4: return 16'hFFFF;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [TW-1:0] word(input int i);
    return {8'(8'h10 + i), 9'(9'h100 + i), 6'(3 + i), 64'h0123_4567_89AB_CDEF ^ 64'(i), pat(i)};
  endfunction

  // Table ROM with one cycle of read latency.
  always @(posedge clk) rom_bus.tbl_data <= word(int'(rom_bus.tbl_addr));

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input int i);
    logic [TW-1:0] w;
    w = word(i);
    check($sformatf("pattern%0d", i), 64'(trace_to_display), 64'(w[CELLS-1:0]));
    check($sformatf("order%0d", i),   64'(trace_order),      64'(w[CELLS +: ORDER_W]));
    check($sformatf("boxes%0d", i),   64'(trace_boxes),      64'(w[CELLS+ORDER_W +: 6]));
    check($sformatf("col%0d", i),     64'(initial_col),      64'(w[CELLS+ORDER_W+6 +: 9]));
    check($sformatf("row%0d", i),     64'(initial_row),      64'(w[CELLS+ORDER_W+15 +: 8]));
  endtask

  typedef struct { logic [CW-1:0] cnt; logic endf; } exp_t;
  exp_t sb[$];

  task automatic expect_after_edge(input string name, input logic [CW-1:0] cnt, input logic endf);
    exp_t e;
    sb.push_back('{cnt, endf});
    step();
    e = sb.pop_front();
    check({name, "_count"}, 64'(trace_count), 64'(e.cnt));
    check({name, "_end"},   64'(end_game_early), 64'(e.endf));
  endtask

  // Entry: trace i shown, state WAIT_CLR or SHOW. Clears the grid, then matches with p.
  task automatic advance(input int i, input logic [15:0] p);
    p1_traced = '0;
    step();
    p1_traced = p;
    expect_after_edge($sformatf("adv%0d", i), CW'(i + 1), (i == N - 1));
    if (i < N - 1) begin
      step();
      step();
      check_word(i + 1);
    end
  endtask

  typedef struct { logic lm; logic ts; logic [15:0] p1; logic [CW-1:0] exp_cnt; } vec_t;
  vec_t vt[6];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    vt[0] = '{1'b1, 1'b1, 16'h0000, 3'd0};
    vt[1] = '{1'b1, 1'b1, 16'h0600, 3'd0};
    vt[2] = '{1'b0, 1'b1, 16'h0660, 3'd0};
    vt[3] = '{1'b1, 1'b0, 16'h0FF0, 3'd0};
    vt[4] = '{1'b0, 1'b0, 16'h0FF0, 3'd0};
    vt[5] = '{1'b1, 1'b1, 16'h0FF0, 3'd1};

    // Reset state
    step();
    step();
    check("rst_pattern", 64'(trace_to_display), 64'h0);
    check("rst_order",   64'(trace_order), 64'h0);
    check("rst_boxes",   64'(trace_boxes), 64'h0);
    check("rst_row",     64'(initial_row), 64'h0);
    check("rst_col",     64'(initial_col), 64'h0);
    check("rst_count",   64'(trace_count), 64'h0);
    check("rst_end",     64'(end_game_early), 64'h0);
    check("rst_addr",    64'(rom_bus.tbl_addr), 64'h0);
    check("rst_timeout", 64'(trace_timeout), 64'h0);

    reset = 1'b0;
    step();
    step();
    check_word(0);
    check("load0_count", 64'(trace_count), 64'h0);

    // Match-rule vectors against trace 0
    for (int i = 0; i < 6; i++) begin
      learn_mode = vt[i].lm;
      trace_screen_on = vt[i].ts;
      p1_traced = vt[i].p1;
      expect_after_edge($sformatf("vec%0d", i), vt[i].exp_cnt, 1'b0);
    end
    step();
    step();
    check_word(1);

    // Held stroke must not pass trace 1
    p1_traced = 16'hFFFF;
    repeat (4) step();
    check("waitclr_count", 64'(trace_count), 64'd1);
    p1_traced = '0;
    step();
    advance(1, 16'h00F0);
    advance(2, 16'h8001);
    advance(3, 16'hFFFF);
    advance(4, 16'hFFFF);

    // DONE holds
    p1_traced = '0;
    step();
    p1_traced = 16'hFFFF;
    step();
    step();
    check("done_count", 64'(trace_count), 64'd5);
    check("done_end",   64'(end_game_early), 64'd1);
    check("done_addr",  64'(rom_bus.tbl_addr), 64'd4);
    check("done_pattern", 64'(trace_to_display), 64'hFFFF);

    // Restart from DONE
    p1_traced = '0;
    restart = 1'b1;
    expect_after_edge("restart", 3'd0, 1'b0);
    restart = 1'b0;
    check("restart_keep_pattern", 64'(trace_to_display), 64'hFFFF);
    step();
    step();
    check_word(0);

    // Restart wins over a simultaneous match
    p1_traced = 16'h0660;
    restart = 1'b1;
    expect_after_edge("restart_vs_match", 3'd0, 1'b0);
    restart = 1'b0;
    p1_traced = '0;
    step();
    step();
    check_word(0);

    // Reset during LOAD of trace 1 clears everything
    p1_traced = 16'h0660;
    expect_after_edge("pre_reset", 3'd1, 1'b0);
    p1_traced = '0;
    step();
    reset = 1'b1;
    #2;
    check("midload_pattern", 64'(trace_to_display), 64'h0);
    check("midload_count",   64'(trace_count), 64'h0);
    check("midload_addr",    64'(rom_bus.tbl_addr), 64'h0);
    reset = 1'b0;
    step();
    step();
    check_word(0);

    // Timeout behaviour while idling in SHOW of trace 0
    learn_mode = 1'b1;
    trace_screen_on = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 24; c++) begin
      step();
`ifdef TRACE_TIMEOUT_EN
      check($sformatf("timeout_c%0d", c), 64'(trace_timeout), 64'((c % 8) == 0));
`endif
      if (trace_timeout) pulses++;
    end
`ifdef TRACE_TIMEOUT_EN
    check("timeout_pulses", 64'(pulses), 64'd3);
`else
    check("timeout_tied", 64'(pulses), 64'd0);
`endif
    check("timeout_count", 64'(trace_count), 64'd0);
    trace_screen_on = 1'b0;
    pulses = 0;
    repeat (20) begin
      step();
      if (trace_timeout) pulses++;
    end
    check("frozen_pulses", 64'(pulses), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
